// File: rtl/matmul_ctrl.sv
// Sequencer for the matrix-multiply datapath: walks C[i][j], issues operand reads,
// strobes the MAC accumulator and writes each finished element to C memory.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand read per cycle, k = 0..K-1
// DRAIN | last read's data reaches the MAC
// WRITE | accumulator written to C[i][j], element index advances
// DONE  | one-cycle completion pulse
module matmul_ctrl #(
  parameter int M  = 2,
  parameter int N  = 2,
  parameter int K  = 2,
  parameter int AW = (M * K > 1) ? $clog2(M * K) : 1,
  parameter int BW = (K * N > 1) ? $clog2(K * N) : 1,
  parameter int CW = (M * N > 1) ? $clog2(M * N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          rd_en,
  output logic [AW-1:0] a_addr,
  output logic [BW-1:0] b_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          c_we,
  output logic [CW-1:0] c_addr,
  output logic          busy,
  output logic          done
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;

  logic          rd_en_q, rd_en_d;
  logic          rd_k0_q, rd_k0_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [BW-1:0] b_addr_q, b_addr_d;
  logic          mac_en_q, mac_en_d;
  logic          mac_clr_q, mac_clr_d;
  logic          c_we_q, c_we_d;
  logic [CW-1:0] c_addr_q, c_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (k_q == KW'(K - 1)) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        state_d = S_RUN;
        if (j_q == JW'(N - 1)) begin
          j_d = '0;
          if (i_q == IW'(M - 1)) begin
            i_d     = '0;
            state_d = S_DONE;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    rd_en_d   = (state_d == S_RUN);
    rd_k0_d   = (state_d == S_RUN) && (k_d == '0);
    a_addr_d  = rd_en_d ? AW'(int'(i_d) * K + int'(k_d)) : '0;
    b_addr_d  = rd_en_d ? BW'(int'(k_d) * N + int'(j_d)) : '0;
    mac_en_d  = rd_en_q;
    mac_clr_d = rd_en_q && rd_k0_q;
    c_we_d    = (state_d == S_WRITE);
    c_addr_d  = c_we_d ? CW'(int'(i_d) * N + int'(j_d)) : '0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      rd_en_q   <= 1'b0;
      rd_k0_q   <= 1'b0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
      c_we_q    <= 1'b0;
      c_addr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      rd_en_q   <= rd_en_d;
      rd_k0_q   <= rd_k0_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      mac_en_q  <= mac_en_d;
      mac_clr_q <= mac_clr_d;
      c_we_q    <= c_we_d;
      c_addr_q  <= c_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign a_addr  = a_addr_q;
  assign b_addr  = b_addr_q;
  assign mac_en  = mac_en_q;
  assign mac_clr = mac_clr_q;
  assign c_we    = c_we_q;
  assign c_addr  = c_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: a 2x2x2 instance with BRAM/MAC models and a K=1, 2x3 instance.
module tb_matmul_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  always #5 clk = ~clk;

  logic       rd0, mac0, clr0, we0, busy0, done0;
  logic [1:0] a0, b0, c0;
  logic       rd1, mac1, clr1, we1, busy1, done1;
  logic [0:0] a1;
  logic [1:0] b1;
  logic [2:0] c1;

  matmul_ctrl #(.M(2), .N(2), .K(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .rd_en(rd0), .a_addr(a0), .b_addr(b0), .mac_en(mac0), .mac_clr(clr0),
    .c_we(we0), .c_addr(c0), .busy(busy0), .done(done0)
  );

  matmul_ctrl #(.M(2), .N(3), .K(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .rd_en(rd1), .a_addr(a1), .b_addr(b1), .mac_en(mac1), .mac_clr(clr1),
    .c_we(we1), .c_addr(c1), .busy(busy1), .done(done1)
  );

  logic [12:0] o0;
  logic [11:0] o1;
  assign o0 = {rd0, a0, b0, mac0, clr0, we0, c0, busy0, done0};
  assign o1 = {rd1, a1, b1, mac1, clr1, we1, c1, busy1, done1};

  // Behavioural operand BRAMs (1-cycle latency), MAC accumulator and C memory.
  int amem [4] = '{1, 2, 3, 4};
  int bmem [4] = '{5, 6, 7, 8};
  int cmem [4] = '{0, 0, 0, 0};
  int a_dat = 0, b_dat = 0, acc = 0;

  always @(posedge clk) begin
    if (rd0) begin
      a_dat <= amem[a0];
      b_dat <= bmem[b0];
    end
    if (mac0) acc <= clr0 ? a_dat * b_dat : acc + a_dat * b_dat;
    if (we0) cmem[c0] <= acc;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       start;
    logic       rd;
    logic [1:0] a;
    logic [1:0] b;
    logic       mac;
    logic       clr;
    logic       we;
    logic [1:0] c;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic st, input logic rd, input int a, input int b,
                              input logic mac, input logic clr, input logic we, input int c,
                              input logic busy, input logic done);
    vec_t v;
    v.start = st; v.rd = rd; v.a = 2'(a); v.b = 2'(b); v.mac = mac; v.clr = clr;
    v.we = we; v.c = 2'(c); v.busy = busy; v.done = done;
    return v;
  endfunction

  function automatic logic [12:0] pack(input vec_t v);
    return {v.rd, v.a, v.b, v.mac, v.clr, v.we, v.c, v.busy, v.done};
  endfunction

  task automatic wait_done0(input string nm);
    int cyc;
    cyc = 0;
    while (!done0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check(nm, 32'(done0), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  int cexp [4] = '{19, 22, 43, 50};

  initial begin
    //            st rd a b mac clr we c busy done
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 1, 1, 2, 1, 1, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[5]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(1, 1, 1, 3, 1, 1, 0, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    tbl[9]  = mk(0, 1, 2, 0, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 1, 3, 2, 1, 1, 0, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 2, 1, 0);
    tbl[13] = mk(0, 1, 2, 1, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(0, 1, 3, 3, 1, 1, 0, 0, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 3, 1, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("reset_u0", 32'(o0), 32'd0);
    check("reset_u1", 32'(o1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2x2 run with stray starts mid-run (cycle 6) and in the DONE cycle (17).
    for (int t = 0; t < 20; t++) begin
      check($sformatf("vec%0d", t), 32'(o0), 32'(pack(tbl[t])));
      start0 = tbl[t].start;
      @(negedge clk);
    end
    start0 = 1'b0;
    for (int e = 0; e < 4; e++) check($sformatf("cmem%0d", e), 32'(cmem[e]), 32'(cexp[e]));

    // K=1, M=2, N=3: three cycles per element, mac_clr on every mac_en.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      int  e, ph, av, bv, cv;
      bit  rd, mac, we, bz, dn;
      e  = (c - 1) / 3;
      ph = (c - 1) % 3;
      rd  = (c <= 18) && (ph == 0);
      mac = (c <= 18) && (ph == 1);
      we  = (c <= 18) && (ph == 2);
      av  = rd ? e / 3 : 0;
      bv  = rd ? e % 3 : 0;
      cv  = we ? e : 0;
      bz  = (c <= 19);
      dn  = (c == 19);
      check($sformatf("k1_cyc%0d", c), 32'(o1),
            32'({rd, 1'(av), 2'(bv), mac, mac, we, 3'(cv), bz, dn}));
      @(negedge clk);
    end

    // start held high: relaunch on the first IDLE cycle after DONE.
    begin
      int cyc;
      start0 = 1'b1;
      @(negedge clk);
      check("held_first_rd", 32'({rd0, a0, busy0}), 32'({1'b1, 2'd0, 1'b1}));
      cyc = 1;
      while (!done0 && cyc < 60) begin
        @(negedge clk);
        cyc++;
      end
      check("held_done_cycle", 32'(cyc), 32'd17);
      @(negedge clk);
      check("held_gap", 32'({rd0, busy0, done0}), 32'd0);
      @(negedge clk);
      check("held_relaunch", 32'({rd0, a0, b0, busy0}), 32'({1'b1, 2'd0, 2'd0, 1'b1}));
      start0 = 1'b0;
      wait_done0("held_second_done");
    end

    // Reset during the second element's RUN.
    begin
      int noisy;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_pre", 32'({rd0, a0, b0}), 32'({1'b1, 2'd0, 2'd1}));
      rst_n = 1'b0;
      #1;
      check("rst_async", 32'(o0), 32'd0);
      @(negedge clk);
      check("rst_hold", 32'(o0), 32'd0);
      check("rst_nox", 32'($isunknown(o0)), 32'd0);
      rst_n = 1'b1;
      noisy = 0;
      for (int n = 0; n < 30; n++) begin
        @(negedge clk);
        if (o0 !== 13'd0) noisy++;
      end
      check("rst_quiet", 32'(noisy), 32'd0);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      check("rst_fresh_rd", 32'({rd0, a0, b0}), 32'({1'b1, 2'd0, 2'd0}));
      repeat (3) @(negedge clk);
      check("rst_fresh_we", 32'({we0, c0}), 32'({1'b1, 2'd0}));
      wait_done0("rst_fresh_done");
    end

    // Reset with start held high, accepted on the first edge after release.
    rst_n  = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    check("rsth_out0", 32'(o0), 32'd0);
    check("rsth_nox0", 32'($isunknown(o0)), 32'd0);
    @(negedge clk);
    check("rsth_out1", 32'(o0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rsth_launch", 32'({rd0, busy0, a0}), 32'({1'b1, 1'b1, 2'd0}));
    check("rsth_nox1", 32'($isunknown(o0)), 32'd0);
    start0 = 1'b0;
    wait_done0("rsth_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
